// File: rtl/anc_audio_tx.sv
// I2S master transmitter for the ANC anti-noise sample: gain/truncate to DAC width, mono MSB-first in both slots.
// Optional build macro ANC_TX_SAT_EN clamps samples that overflow the gain shift instead of wrapping.
module anc_audio_tx #(
  parameter int INP_OUT_WIDTH = 24,
  parameter int DAC_WIDTH     = 16,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_HALF     = 4,
  parameter int GAIN_SHL      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [INP_OUT_WIDTH-1:0] yn,
  input  logic                            yn_valid,
  output logic                            yn_ready,
  output logic                            bclk,
  output logic                            lrck,
  output logic                            dacdat,
  output logic                            audio_tx_down,
  output logic                            tx_underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = $clog2(BCLK_HALF);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     nxt_bit;
  logic [BIT_W-1:0]     nxt_off;
  logic [DAC_WIDTH-1:0] hold;
  logic [DAC_WIDTH-1:0] last;
  logic [DAC_WIDTH-1:0] shreg;
  logic [DAC_WIDTH-1:0] slot_word;
  logic                 hold_full;
  logic                 div_end;
  logic                 fall;
  logic                 frame_start;
  logic                 capture;

  function automatic logic [DAC_WIDTH-1:0] scale_sample(input logic signed [INP_OUT_WIDTH-1:0] x);
    logic signed [INP_OUT_WIDTH-1:0] s;
    s = x <<< GAIN_SHL;
`ifdef ANC_TX_SAT_EN
    // Bits that the gain shift would push out must all match the sign, otherwise clamp.
    if (x[INP_OUT_WIDTH-1 -: GAIN_SHL+1] != {(GAIN_SHL+1){x[INP_OUT_WIDTH-1]}}) begin
      return x[INP_OUT_WIDTH-1] ? {1'b1, {(DAC_WIDTH-1){1'b0}}} : {1'b0, {(DAC_WIDTH-1){1'b1}}};
    end
`endif
    return s[INP_OUT_WIDTH-1 -: DAC_WIDTH];
  endfunction

  assign yn_ready    = !hold_full;
  assign capture     = yn_valid && !hold_full;
  assign div_end     = (div_cnt == DIV_W'(BCLK_HALF - 1));
  assign fall        = div_end && bclk;
  assign frame_start = (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign nxt_bit     = frame_start ? '0 : bit_cnt + 1'b1;
  assign nxt_off     = (nxt_bit >= BIT_W'(SLOT_BITS)) ? nxt_bit - BIT_W'(SLOT_BITS) : nxt_bit;
  assign slot_word   = (frame_start && hold_full) ? hold : last;

  // Stage p0: bit clock divider and frame position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrck    <= 1'b0;
    end else begin
      if (div_end) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall) begin
        bit_cnt <= nxt_bit;
        lrck    <= (nxt_bit >= BIT_W'(SLOT_BITS));
      end
    end
  end

  // Stage p1: sample holding register and frame commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold          <= '0;
      hold_full     <= 1'b0;
      last          <= '0;
      audio_tx_down <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      audio_tx_down <= 1'b0;
      tx_underrun   <= 1'b0;
      if (fall && frame_start) begin
        if (hold_full) begin
          last          <= hold;
          audio_tx_down <= 1'b1;
        end else begin
          tx_underrun   <= 1'b1;
        end
      end
      if (fall && frame_start && hold_full) begin
        hold_full <= 1'b0;
      end else if (capture) begin
        hold      <= scale_sample(yn);
        hold_full <= 1'b1;
      end
    end
  end

  // Stage p2: serializer, one-bit I2S delay after each slot boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      dacdat <= 1'b0;
    end else if (fall) begin
      if (nxt_off == '0) begin
        shreg  <= slot_word;
        dacdat <= 1'b0;
      end else if (nxt_off <= BIT_W'(DAC_WIDTH)) begin
        dacdat <= shreg[DAC_WIDTH-1];
        shreg  <= {shreg[DAC_WIDTH-2:0], 1'b0};
      end else begin
        dacdat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_anc_audio_tx.sv
// Scoreboard bench for anc_audio_tx: random and directed samples, slot decoding, frame timing and reset checks.
module tb_anc_audio_tx;
  localparam int IW = 24;
  localparam int DW = 16;
  localparam int SB = 32;
  localparam int BH = 4;
  localparam int GS = 2;
  localparam int FRAME_CLK = 2 * SB * 2 * BH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [IW-1:0] yn = '0;
  logic                 yn_valid = 1'b0;
  logic                 yn_ready, bclk, lrck, dacdat, audio_tx_down, tx_underrun;

  anc_audio_tx #(.INP_OUT_WIDTH(IW), .DAC_WIDTH(DW), .SLOT_BITS(SB), .BCLK_HALF(BH), .GAIN_SHL(GS)) dut (
    .clk(clk), .rst_n(rst_n), .yn(yn), .yn_valid(yn_valid), .yn_ready(yn_ready),
    .bclk(bclk), .lrck(lrck), .dacdat(dacdat), .audio_tx_down(audio_tx_down), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion in plain integer arithmetic.
  function automatic logic [DW-1:0] model(input logic [IW-1:0] v);
    longint x, y, m;
    m = longint'(1) << IW;
    x = longint'(v);
    if (x >= (m >> 1)) x = x - m;
    y = x * (longint'(1) << GS);
`ifdef ANC_TX_SAT_EN
    if (y > (m >> 1) - 1) return DW'((longint'(1) << (DW - 1)) - 1);
    if (y < -(m >> 1)) return DW'(longint'(1) << (DW - 1));
`endif
    y = ((y % m) + m) % m;
    return DW'(y / (longint'(1) << (IW - DW)));
  endfunction

  // Monitor: decodes slots at BCLK rises and compares against the scoreboard.
  logic          prev_bclk = 1'b0;
  int            last_rise = -1;
  int            last_frame = -1;
  int            slot_cnt = 0;
  logic          slot_lr = 1'b0;
  logic          slot_active = 1'b0;
  logic [DW-1:0] slot_word = '0;
  logic [DW-1:0] slot_exp = '0;
  logic          slot_tail_bad = 1'b0;
  int            n_down = 0;
  int            n_under = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {58'd0, bclk, lrck, dacdat, audio_tx_down, tx_underrun, yn_ready}, 64'h1);
      prev_bclk = 1'b0; last_rise = -1; last_frame = -1;
      slot_active = 1'b1; slot_cnt = 0; slot_lr = 1'b0; slot_word = '0; slot_tail_bad = 1'b0;
      cur_word = '0; slot_exp = '0;
      exp_q.delete();
    end else begin
      if (audio_tx_down || tx_underrun) begin
        check("frame_event_exclusive", {63'd0, audio_tx_down & tx_underrun}, 64'd0);
        if (last_frame >= 0) check("frame_period", 64'(cyc - last_frame), 64'(FRAME_CLK));
        last_frame = cyc;
      end
      if (audio_tx_down) begin
        n_down++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_down_unexpected: got pulse required no pending sample (t=%0t)", $time);
        end else begin
          cur_word = exp_q.pop_front();
        end
      end
      if (tx_underrun) n_under++;
      if (bclk && !prev_bclk) begin
        if (last_rise >= 0) check("bclk_period", 64'(cyc - last_rise), 64'(2 * BH));
        last_rise = cyc;
        if (lrck != slot_lr) begin
          if (slot_active) begin
            check("slot_length", 64'(slot_cnt), 64'(SB));
            check("slot_word", 64'(slot_word), 64'(slot_exp));
            check("slot_padding", {63'd0, slot_tail_bad}, 64'd0);
          end
          slot_active = 1'b1; slot_lr = lrck; slot_cnt = 0;
          slot_word = '0; slot_tail_bad = 1'b0; slot_exp = cur_word;
        end
        if (slot_cnt >= 1 && slot_cnt <= DW) slot_word = {slot_word[DW-2:0], dacdat};
        else if (dacdat) slot_tail_bad = 1'b1;
        slot_cnt++;
      end
      prev_bclk = bclk;
    end
  end

  task automatic send(input logic [IW-1:0] v);
    int w;
    w = 0;
    @(negedge clk);
    while (!yn_ready && w < 3 * FRAME_CLK) begin
      @(negedge clk);
      w++;
    end
    if (!yn_ready) begin
      check("send_ready_timeout", {63'd0, yn_ready}, 64'd1);
      return;
    end
    yn = v;
    yn_valid = 1'b1;
    exp_q.push_back(model(v));
    @(negedge clk);
    yn_valid = 1'b0;
    check("ready_drop", {63'd0, yn_ready}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, u0, w, rel;
    logic [IW-1:0] data;
    logic acc;
    logic [IW-1:0] dir[6];
    dir[0] = 24'h001234; dir[1] = 24'hFFFFF0; dir[2] = 24'h300000;
    dir[3] = 24'hC00000; dir[4] = 24'h7FFFFF; dir[5] = 24'h800000;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle: underrun every frame, no commits, silent data.
    d0 = n_down; u0 = n_under;
    repeat (2 * FRAME_CLK + 8) @(negedge clk);
    check("idle_underruns", 64'(n_under - u0), 64'd2);
    check("idle_tx_down", 64'(n_down - d0), 64'd0);

    for (int i = 0; i < 6; i++) send(dir[i]);
    for (int i = 0; i < 6; i++) send(IW'($urandom));

    // Streaming source: valid held high with incrementing data.
    data = IW'($urandom);
    acc = 1'b0;
    for (int i = 0; i < 6 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (acc) data = data + 1'b1;
      yn = data;
      yn_valid = 1'b1;
      acc = yn_ready;
      if (yn_ready) exp_q.push_back(model(data));
      if (i == 700) begin
        #2;
        d0 = n_down; u0 = n_under;
      end
      if (i == 700 + 4 * FRAME_CLK) begin
        #2;
        check("stream_tx_down", 64'(n_down - d0), 64'd4);
        check("stream_underruns", 64'(n_under - u0), 64'd0);
      end
    end
    @(negedge clk);
    yn_valid = 1'b0;

    w = 0;
    while (exp_q.size() != 0 && w < 3 * FRAME_CLK) begin
      @(negedge clk);
      w++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (FRAME_CLK + 4 * SB) @(negedge clk);

    // Reset in the middle of the right slot.
    w = 0;
    while (!lrck && w < FRAME_CLK) begin
      @(negedge clk);
      w++;
    end
    check("reach_right_slot", {63'd0, lrck}, 64'd1);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_bclk", {63'd0, bclk}, 64'd0);
    check("async_reset_lrck", {63'd0, lrck}, 64'd0);
    check("async_reset_dacdat", {63'd0, dacdat}, 64'd0);
    check("async_reset_ready", {63'd0, yn_ready}, 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!tx_underrun && w < FRAME_CLK + 16);
    check("post_reset_underrun", {63'd0, tx_underrun}, 64'd1);
    check("post_reset_alignment", 64'(cyc - rel), 64'(FRAME_CLK));
    d0 = n_down;
    repeat (FRAME_CLK + 4 * SB) @(negedge clk);
    check("post_reset_tx_down", 64'(n_down - d0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
